piece_mover: RTL and testbench
==============================

Name: piece_mover

Overview:
- Control-side counterpart of the piece/field holding register.
- Reads the current piece coordinates (four cells) and the field bus, then computes a candidate move on gravity tick or button press.
- Checks the candidate cell by cell against the walls and the occupied field, then drives the step_3 buses with the is_write_reg/is_touch controls.
- Produces exactly one write pulse per accepted move or landing.

Parameters:
- MEM_WIDTH, 4, number of field rows; y range 0..MEM_WIDTH-1, row 0 is the top.
- WIDTH, 8, bits per coordinate and bits per field row; x range 0..WIDTH-1; must be at least 4.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- coord_x_step_1  in  WIDTH*4  current cell x; cell i at [WIDTH*(4-i)-1:WIDTH*(3-i)].
- coord_y_step_1  in  WIDTH*4  current cell y; same packing.
- bus_step_1  in  WIDTH*MEM_WIDTH  field; row k at [WIDTH*(MEM_WIDTH-k)-1:WIDTH*(MEM_WIDTH-k-1)]; column c = row bit WIDTH-1-c.
- tick  in  1  gravity request (move down), single-cycle pulse.
- btn_left  in  1  move-left request, single-cycle pulse.
- btn_right  in  1  move-right request, single-cycle pulse.
- new_coord_x_step_3  out  WIDTH*4  candidate x, registered.
- new_coord_y_step_3  out  WIDTH*4  candidate y, registered.
- new_bus_step_3  out  WIDTH*MEM_WIDTH  field to write, registered.
- is_write_reg  out  1  one-cycle load strobe for the holding register.
- is_touch  out  1  one-cycle landing strobe; asserted only together with is_write_reg.
- busy  out  1  high whenever state is not IDLE.
- game_over  out  1  sticky flag.

Behaviour:
- Reset (rst=0 at an edge), whatever the state:
  - state goes to IDLE.
  - is_write_reg=0, is_touch=0, busy=0, game_over=0, pending tick cleared.
  - new_coord_x = {0,1,2,3}, new_coord_y = all 0, new_bus = all 0.
- States: IDLE, CALC, CHECK, COMMIT, LAND, DROP.
- IDLE:
  - If game_over=1, all requests are ignored.
  - Otherwise a request (or a pending tick) is latched as cmd, priority tick > btn_left > btn_right, and state goes to CALC.
- CALC (1 cycle):
  - Register the candidate: down is y+1, left is x-1, right is x+1, applied to all four cells; other axis unchanged.
  - Clear the cell counter.
- CHECK (4 cycles, cell 0..3, one per cycle). Cell i collides if any of:
  - cmd=left and current x_i==0;
  - cmd=right and current x_i==WIDTH-1;
  - cmd=down and current y_i==MEM_WIDTH-1;
  - otherwise, field bit at (candidate y_i, candidate x_i) ==1.
  - Collision flag is ORed across all cells; all four cells are always checked.
- After CHECK:
  - No collision → COMMIT.
  - Collision with cmd=down → LAND.
  - Collision with cmd=left or right → DROP.
- COMMIT (1 cycle):
  - is_write_reg=1, is_touch=0.
  - new_coord = candidate; new_bus = bus_step_1 unchanged.
- LAND (1 cycle):
  - is_write_reg=1, is_touch=1.
  - new_bus = bus_step_1 OR the bits of the four current cells.
  - new_coord = current coords; the holding register reloads spawn via is_touch.
  - If the merged field has any of row 0, columns 0..3 set, game_over is set on the next edge.
- DROP (1 cycle): no strobes, outputs hold.
- After COMMIT, LAND or DROP, state returns to IDLE.
- Latency: request accepted in IDLE at cycle t → strobe (or DROP) at t+6 → IDLE again at t+7, so busy is high t+1..t+6.
- Requests while busy:
  - tick sets a one-deep pending flag, served in the next IDLE; a second tick while pending is lost.
  - Buttons are ignored.
- Stability: new_* outputs hold their last value between strobes. The step_1 inputs are stable while busy because only this block strobes the register.

Test Plan:
- Reset, field rows all 8'h03, piece x={0,1,2,3} y=0, tick at t → at t+6 is_write_reg=1, is_touch=0, new_y={1,1,1,1}, new_x={0,1,2,3}; busy low at t+7.
- Same start, btn_left → DROP: no is_write_reg during t..t+7, busy high t+1..t+6.
- Same start, btn_right → COMMIT with new_x={1,2,3,4}, new_y all 0.
- Piece at y=3 (MEM_WIDTH=4), rows 8'h03, tick → LAND: is_write_reg=is_touch=1 in the same cycle, new_bus row 3 = 8'hF3, other rows 8'h03, game_over stays 0.
- Piece at y=0, row 1 = 8'h20 (column 2 occupied), tick → LAND with row 0 = 8'hF3 → game_over=1 next cycle; later tick/btn produce no busy and no strobe until rst=0.
- tick and btn_left in the same cycle → down executes, left discarded; tick at t+2 while busy → second down move strobes at t+13; rst=0 at t+3 → no strobe, pending cleared, outputs at reset values.

Source files
------------

// File: rtl/piece_mover.sv
// piece_mover: move controller for a falling four-cell piece. It takes a
// gravity tick or a left/right button request, builds the shifted candidate,
// checks each of the four cells against the walls and the occupied field, and
// then produces a single registered strobe for an accepted move or a landing.
module piece_mover #(
    parameter int MEM_WIDTH = 4,
    parameter int WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH*4-1:0]         coord_x_step_1,
    input  logic [WIDTH*4-1:0]         coord_y_step_1,
    input  logic [WIDTH*MEM_WIDTH-1:0] bus_step_1,
    input  logic                       tick,
    input  logic                       btn_left,
    input  logic                       btn_right,
    output logic [WIDTH*4-1:0]         new_coord_x_step_3,
    output logic [WIDTH*4-1:0]         new_coord_y_step_3,
    output logic [WIDTH*MEM_WIDTH-1:0] new_bus_step_3,
    output logic                       is_write_reg,
    output logic                       is_touch,
    output logic                       busy,
    output logic                       game_over
);

    localparam int CW = WIDTH * 4;
    localparam int BW = WIDTH * MEM_WIDTH;
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CALC   = 3'd1,
        CHECK  = 3'd2,
        COMMIT = 3'd3,
        LAND   = 3'd4,
        DROP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CMD_DOWN  = 2'd0,
        CMD_LEFT  = 2'd1,
        CMD_RIGHT = 2'd2
    } cmd_t;

    state_t          state_r;
    cmd_t            cmd_r;
    logic [1:0]      cnt_r;
    logic            coll_r;
    logic            pending_r;
    logic            game_over_r;
    logic            busy_r;
    logic            is_write_r;
    logic            is_touch_r;
    logic [CW-1:0]   new_x_r;
    logic [CW-1:0]   new_y_r;
    logic [BW-1:0]   new_bus_r;
    logic [CW-1:0]   cand_x_r;
    logic [CW-1:0]   cand_y_r;

    logic [WIDTH-1:0] nx_s [4];
    logic [WIDTH-1:0] ny_s [4];
    logic [CW-1:0]    cand_x_s;
    logic [CW-1:0]    cand_y_s;
    logic [BW-1:0]    land_bus_s;
    logic [WIDTH-1:0] cur_x_s;
    logic [WIDTH-1:0] cur_y_s;
    logic [WIDTH-1:0] chk_x_s;
    logic [WIDTH-1:0] chk_y_s;
    logic             hit_s;
    logic             coll_any_s;

    // Cell i sits in the i-th byte counted from the most significant end.
    function automatic logic [WIDTH-1:0] cell_of(input logic [CW-1:0] v, input int i);
        return WIDTH'(v >> (WIDTH * (3 - i)));
    endfunction

    // One-hot field mask for cell (y, x); rows outside the field give no bit.
    function automatic logic [BW-1:0] cell_mask(input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] x);
        logic [BW-1:0] one;
        one = {{(BW-1){1'b0}}, 1'b1};
        if (int'(y) >= MEM_WIDTH) begin
            return {BW{1'b0}};
        end else begin
            return one << (WIDTH * (MEM_WIDTH - 1 - int'(y)) + (WIDTH - 1 - int'(x)));
        end
    endfunction

    // A cell outside the field counts as occupied so it can never be accepted.
    function automatic logic field_bit(input logic [BW-1:0] bus, input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] x);
        if (int'(y) >= MEM_WIDTH) begin
            return 1'b1;
        end else begin
            return |(bus & cell_mask(y, x));
        end
    endfunction

    // Candidate position for the latched command plus the landed field image.
    always_comb begin
        land_bus_s = bus_step_1;
        for (int i = 0; i < 4; i++) begin
            nx_s[i] = cell_of(coord_x_step_1, i);
            ny_s[i] = cell_of(coord_y_step_1, i);
            land_bus_s = land_bus_s | cell_mask(ny_s[i], nx_s[i]);
            case (cmd_r)
                CMD_DOWN:  ny_s[i] = ny_s[i] + ONE_C;
                CMD_LEFT:  nx_s[i] = nx_s[i] - ONE_C;
                CMD_RIGHT: nx_s[i] = nx_s[i] + ONE_C;
                default:   nx_s[i] = nx_s[i];
            endcase
        end
        cand_x_s = {nx_s[0], nx_s[1], nx_s[2], nx_s[3]};
        cand_y_s = {ny_s[0], ny_s[1], ny_s[2], ny_s[3]};
    end

    // Collision test for the cell selected by the counter, wall checks first.
    always_comb begin
        cur_x_s = cell_of(coord_x_step_1, int'(cnt_r));
        cur_y_s = cell_of(coord_y_step_1, int'(cnt_r));
        chk_x_s = cell_of(cand_x_r, int'(cnt_r));
        chk_y_s = cell_of(cand_y_r, int'(cnt_r));
        hit_s   = 1'b1;
        case (cmd_r)
            CMD_LEFT: begin
                if (cur_x_s == ZERO_C) hit_s = 1'b1;
                else                   hit_s = field_bit(bus_step_1, chk_y_s, chk_x_s);
            end
            CMD_RIGHT: begin
                if (int'(cur_x_s) == WIDTH - 1) hit_s = 1'b1;
                else                            hit_s = field_bit(bus_step_1, chk_y_s, chk_x_s);
            end
            CMD_DOWN: begin
                if (int'(cur_y_s) == MEM_WIDTH - 1) hit_s = 1'b1;
                else                                hit_s = field_bit(bus_step_1, chk_y_s, chk_x_s);
            end
            default: hit_s = 1'b1;
        endcase
        coll_any_s = coll_r | hit_s;
    end

    // Move sequencer; every output is registered and strobes last one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            cmd_r       <= CMD_DOWN;
            cnt_r       <= 2'd0;
            coll_r      <= 1'b0;
            pending_r   <= 1'b0;
            game_over_r <= 1'b0;
            busy_r      <= 1'b0;
            is_write_r  <= 1'b0;
            is_touch_r  <= 1'b0;
            new_x_r     <= {WIDTH'(0), WIDTH'(1), WIDTH'(2), WIDTH'(3)};
            new_y_r     <= {CW{1'b0}};
            new_bus_r   <= {BW{1'b0}};
            cand_x_r    <= {CW{1'b0}};
            cand_y_r    <= {CW{1'b0}};
        end else begin
            is_write_r <= 1'b0;
            is_touch_r <= 1'b0;
            if (state_r != IDLE && tick) pending_r <= 1'b1;
            case (state_r)
                IDLE: begin
                    if (game_over_r) begin
                        pending_r <= 1'b0;
                    end else if (tick || pending_r) begin
                        cmd_r     <= CMD_DOWN;
                        pending_r <= 1'b0;
                        state_r   <= CALC;
                        busy_r    <= 1'b1;
                    end else if (btn_left) begin
                        cmd_r   <= CMD_LEFT;
                        state_r <= CALC;
                        busy_r  <= 1'b1;
                    end else if (btn_right) begin
                        cmd_r   <= CMD_RIGHT;
                        state_r <= CALC;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    cand_x_r <= cand_x_s;
                    cand_y_r <= cand_y_s;
                    cnt_r    <= 2'd0;
                    coll_r   <= 1'b0;
                    state_r  <= CHECK;
                end
                CHECK: begin
                    if (cnt_r == 2'd3) begin
                        if (!coll_any_s) begin
                            state_r    <= COMMIT;
                            is_write_r <= 1'b1;
                            new_x_r    <= cand_x_r;
                            new_y_r    <= cand_y_r;
                            new_bus_r  <= bus_step_1;
                        end else if (cmd_r == CMD_DOWN) begin
                            state_r    <= LAND;
                            is_write_r <= 1'b1;
                            is_touch_r <= 1'b1;
                            new_x_r    <= coord_x_step_1;
                            new_y_r    <= coord_y_step_1;
                            new_bus_r  <= land_bus_s;
                        end else begin
                            state_r <= DROP;
                        end
                    end else begin
                        cnt_r  <= cnt_r + 2'd1;
                        coll_r <= coll_any_s;
                    end
                end
                LAND: begin
                    if (new_bus_r[BW-1 -: 4] != 4'b0000) game_over_r <= 1'b1;
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                COMMIT, DROP: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign new_coord_x_step_3 = new_x_r;
    assign new_coord_y_step_3 = new_y_r;
    assign new_bus_step_3     = new_bus_r;
    assign is_write_reg       = is_write_r;
    assign is_touch           = is_touch_r;
    assign busy               = busy_r;
    assign game_over          = game_over_r;

endmodule

// File: tb/tb_piece_mover.sv
// Bench for piece_mover: directed requests push expected strobes into a
// scoreboard queue; a monitor pops and compares whenever is_write_reg fires.
module tb_piece_mover;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] coord_x_step_1 = 32'h0;
    logic [31:0] coord_y_step_1 = 32'h0;
    logic [31:0] bus_step_1 = 32'h0;
    logic        tick = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic [31:0] new_coord_x_step_3;
    logic [31:0] new_coord_y_step_3;
    logic [31:0] new_bus_step_3;
    logic        is_write_reg;
    logic        is_touch;
    logic        busy;
    logic        game_over;

    typedef struct {
        int          cyc;
        logic        touch;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] bus;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    piece_mover #(.MEM_WIDTH(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .coord_x_step_1(coord_x_step_1), .coord_y_step_1(coord_y_step_1),
        .bus_step_1(bus_step_1), .tick(tick), .btn_left(btn_left), .btn_right(btn_right),
        .new_coord_x_step_3(new_coord_x_step_3), .new_coord_y_step_3(new_coord_y_step_3),
        .new_bus_step_3(new_bus_step_3), .is_write_reg(is_write_reg), .is_touch(is_touch),
        .busy(busy), .game_over(game_over)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (is_touch === 1'b1 && is_write_reg !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL touch_without_write at cycle %0d", cyc);
        end
        if (is_write_reg === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe at cycle %0d x=%h y=%h", cyc, new_coord_x_step_3, new_coord_y_step_3);
            end else begin
                e = sb.pop_front();
                chk("strobe_cycle", cyc, e.cyc);
                chk("strobe_touch", {31'd0, is_touch}, {31'd0, e.touch});
                chk("strobe_x", new_coord_x_step_3, e.x);
                chk("strobe_y", new_coord_y_step_3, e.y);
                chk("strobe_bus", new_bus_step_3, e.bus);
            end
        end
    end

    task automatic expect_strobe(input int at, input logic touch, input logic [31:0] x, input logic [31:0] y, input logic [31:0] b);
        exp_t e;
        e.cyc = at; e.touch = touch; e.x = x; e.y = y; e.bus = b;
        sb.push_back(e);
    endtask

    // One request with busy profile checks; strobe expected six cycles later.
    task automatic issue(input logic t, input logic l, input logic r, input bit strobe,
                         input logic touch, input logic [31:0] ex, input logic [31:0] ey, input logic [31:0] eb);
        int c0;
        @(negedge clk);
        c0 = cyc;
        if (strobe) expect_strobe(c0 + 6, touch, ex, ey, eb);
        tick = t; btn_left = l; btn_right = r;
        @(negedge clk);
        tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            chk("busy_profile", {31'd0, busy}, {31'd0, (k <= 6)});
            if (k < 7) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_x"}, new_coord_x_step_3, 32'h00010203);
        chk({tag, "_y"}, new_coord_y_step_3, 32'h00000000);
        chk({tag, "_bus"}, new_bus_step_3, 32'h00000000);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_gameover"}, {31'd0, game_over}, 32'd0);
        chk({tag, "_write"}, {31'd0, is_write_reg}, 32'd0);
    endtask

    initial begin
        int c0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        coord_x_step_1 = 32'h00010203;
        coord_y_step_1 = 32'h00000000;
        bus_step_1     = 32'h03030303;

        // Gravity move into free rows.
        issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00010203, 32'h01010101, 32'h03030303);
        // Left against the wall: dropped, outputs hold.
        issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("drop_hold_y", new_coord_y_step_3, 32'h01010101);
        // Right move into free columns.
        issue(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h01020304, 32'h00000000, 32'h03030303);

        // Bottom row: landing merges the piece into row 3.
        coord_y_step_1 = 32'h03030303;
        issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00010203, 32'h03030303, 32'h030303F3);
        chk("land_no_gameover", {31'd0, game_over}, 32'd0);

        // Blocked by column 2 in row 1 while still in row 0: game over.
        coord_y_step_1 = 32'h00000000;
        bus_step_1     = 32'h03230303;
        issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00010203, 32'h00000000, 32'hF3230303);
        chk("gameover_set", {31'd0, game_over}, 32'd1);
        @(negedge clk); tick = 1'b1; btn_right = 1'b1;
        @(negedge clk); tick = 1'b0; btn_right = 1'b0;
        repeat (3) begin
            chk("gameover_idle_busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
        end
        chk("gameover_sticky", {31'd0, game_over}, 32'd1);
        do_reset();
        chk("gameover_cleared", {31'd0, game_over}, 32'd0);

        // Tick beats left; a tick while busy is served as a second move.
        bus_step_1 = 32'h03030303;
        @(negedge clk);
        c0 = cyc;
        expect_strobe(c0 + 6, 1'b0, 32'h00010203, 32'h01010101, 32'h03030303);
        expect_strobe(c0 + 13, 1'b0, 32'h00010203, 32'h01010101, 32'h03030303);
        tick = 1'b1; btn_left = 1'b1;
        @(negedge clk); tick = 1'b0; btn_left = 1'b0;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        while (cyc < c0 + 7) @(negedge clk);
        chk("pending_gap_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("pending_serve_busy", {31'd0, busy}, 32'd1);
        while (cyc < c0 + 16) @(negedge clk);

        // Reset mid-move drops the move and the pending tick.
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0; rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        check_reset_outputs("midreset");
        repeat (20) @(negedge clk);
        check_reset_outputs("after_midreset");

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound so a stuck run still reports.
    initial begin
        #20000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
